serial_pattern_feeder: RTL and testbench
========================================

// Module: serial_pattern_feeder
// PURPOSE
//  Parallel-to-serial front end for the 1-0-1 sequence detector.
//  - Accepts a DATA_W-bit word over a valid/ready load handshake.
//  - Shifts the word out one bit at a time; each bit is held for BIT_CYCLES clocks.
//  - bit_out drives the detector's serial input din; bit_valid marks live bits.
// PARAMETERS
//  DATA_W      8  word width in bits; legal range >= 2
//  BIT_CYCLES  1  clocks each bit is held on bit_out; legal range >= 1
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous active-low reset
//  ena         in   1       1 = run; 0 = freeze all state and outputs
//  load_valid  in   1       a word is offered on load_data
//  load_data   in   DATA_W  word to serialize
//  msb_first   in   1       1 = MSB out first, 0 = LSB first; sampled at load only
//  load_ready  out  1       block can accept a word this cycle
//  bit_out     out  1       serial bit to detector din; 0 when not valid
//  bit_valid   out  1       bit_out carries a live bit
//  busy        out  1       a word is being shifted (state SHIFT)
//  done        out  1       1-cycle pulse after the final bit period of a word
// BEHAVIOUR
//  - Reset: state IDLE, shift reg 0, counters 0.
//    Outputs at reset: load_ready=1, bit_out=0, bit_valid=0, busy=0, done=0.
//  - Reset asserted mid-word aborts the word and discards remaining bits. There is no done pulse.
//  - FSM states: IDLE, SHIFT.
//    - IDLE: load_ready=1. If load_valid=1 at a posedge (with ena=1):
//      capture load_data and msb_first, clear bit_idx and hold_cnt, move to SHIFT.
//    - SHIFT: bit_valid=1, busy=1, bit_out = current bit, all registered.
//      hold_cnt counts 0..BIT_CYCLES-1; at its end, bit_idx increments and the next bit is presented.
//    - Leave SHIFT at the posedge ending the last clock of bit DATA_W-1.
//      Go to IDLE, or straight back to SHIFT under SER_CONT_EN.
//  - Latency: first bit appears on the cycle after the accepting edge.
//    A word occupies DATA_W*BIT_CYCLES cycles of bit_valid.
//  - done is registered and high for exactly the one cycle after the final bit period.
//  - Counter widths: bit_idx is $clog2(DATA_W), hold_cnt is $clog2(BIT_CYCLES)+1. No wrap inside a word.
//  - ena=0: no state, counter or output changes.
//    A load_valid seen while ena=0 is not accepted, and load_ready is forced to 0.
//  - load_valid while load_ready=0 is ignored. The source holds the word until accepted.
//  - load_data and msb_first changing during SHIFT have no effect.
// CONFIGURATION
//  SER_CONT_EN defined: back-to-back mode.
//    - load_ready is also 1 during the last clock of bit DATA_W-1.
//    - A load accepted on that edge starts the new word next cycle, so there is no bit_valid gap.
//    - done still pulses for the finished word.
//  SER_CONT_EN undefined: load_ready=0 throughout SHIFT.
//    Consecutive words are separated by at least one cycle with bit_valid=0.
// TESTING
//  1. DATA_W=8, BIT_CYCLES=1: load 0x0D, msb_first=1 -> bit_out 0,0,0,0,1,1,0,1 on 8 cycles.
//     Then done=1 for 1 cycle, load_ready=1.
//  2. Load 0x0D, msb_first=0 -> bit_out 1,0,1,1,0,0,0,0.
//     Fed into the detector, this gives z=1 on the cycle after the third bit.
//  3. BIT_CYCLES=3, load 0x80, MSB first -> bit_out=1 for 3 cycles, then 0 for 21 cycles.
//     bit_valid is high for 24 cycles.
//  4. Pull rst_n low after 4 bits of 0xFF -> all outputs return to reset values at once.
//     No done pulse; a new load is accepted after release.
//  5. Drop ena for 5 cycles mid-word -> bit_out, bit_valid and counters hold.
//     The word resumes intact; total bit_valid cycles = 8.
//  6. Back-to-back 0xAA then 0x55 with load_valid held -> with SER_CONT_EN, 16 contiguous valid bits.
//     Without SER_CONT_EN, exactly 1 idle cycle between the two words.

Source files
------------

// File: rtl/serial_pattern_feeder.sv
// rtl/serial_pattern_feeder.sv - parallel-to-serial bit feeder for the 1-0-1 sequence detector
//
// Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one
// bit at a time, each bit held for BIT_CYCLES clocks.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   ena         in   1 = run, 0 = freeze all state and outputs
//   load_valid  in   a word is offered on load_data
//   load_data   in   [DATA_W-1:0] word to serialize
//   msb_first   in   1 = MSB first, 0 = LSB first (sampled at load)
//   load_ready  out  a word can be accepted this cycle
//   bit_out     out  serial bit to detector din, 0 when not valid
//   bit_valid   out  bit_out carries a live bit
//   busy        out  a word is being shifted
//   done        out  one-cycle pulse after the final bit period
//
// Build option: SER_CONT_EN enables back-to-back words (load_ready also high
// during the last clock of the last bit, so consecutive words have no gap).

module serial_pattern_feeder #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              msb_first,
  output logic              load_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam int IW = $clog2(DATA_W);
  localparam int HW = $clog2(BIT_CYCLES) + 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BIT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              msb_q, msb_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_clk;

  // Final clock of the final bit of the current word.
  assign last_clk = (state_q == SHIFT) && (hold_cnt_q == HOLD_LAST) &&
                    (bit_idx_q == IDX_LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    msb_d       = msb_q;
    bit_idx_d   = bit_idx_q;
    hold_cnt_d  = hold_cnt_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = bit_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    load_ready  = 1'b0;

    if (ena) begin
      done_d = 1'b0;
      if (state_q == IDLE) begin
        load_ready = 1'b1;
      end
`ifdef SER_CONT_EN
      if (last_clk) begin
        load_ready = 1'b1;
      end
`endif

      if (state_q == SHIFT) begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else if (bit_idx_q != IDX_LAST) begin
          // The register always holds the presented bit at its output end,
          // so the next bit is the neighbour of that end.
          hold_cnt_d = '0;
          bit_idx_d  = bit_idx_q + IDX_ONE;
          if (msb_q) begin
            shreg_d   = shreg_q << 1;
            bit_out_d = shreg_q[DATA_W-2];
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_out_d = shreg_q[1];
          end
        end else begin
          done_d      = 1'b1;
          state_d     = IDLE;
          bit_out_d   = 1'b0;
          bit_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end

      // A load overrides the end-of-word return to IDLE (back-to-back case).
      if (load_ready && load_valid) begin
        state_d     = SHIFT;
        shreg_d     = load_data;
        msb_d       = msb_first;
        bit_idx_d   = '0;
        hold_cnt_d  = '0;
        bit_out_d   = msb_first ? load_data[DATA_W-1] : load_data[0];
        bit_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      msb_q       <= 1'b0;
      bit_idx_q   <= '0;
      hold_cnt_q  <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      msb_q       <= msb_d;
      bit_idx_q   <= bit_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// tb/tb_serial_pattern_feeder.sv - scoreboard bench for serial_pattern_feeder

module tb_serial_pattern_feeder;

  logic       clk;
  logic       rst_n;
  logic       ena;

  logic       a_load_valid, a_msb, a_load_ready, a_bit, a_valid, a_busy, a_done;
  logic [7:0] a_load_data;
  logic       b_load_valid, b_msb, b_load_ready, b_bit, b_valid, b_busy, b_done;
  logic [7:0] b_load_data;

  int tests = 0;
  int fails = 0;
  int vcnt_a, vcnt_b, done_a, done_b, gap, acc2;
  logic a_acc, b_acc;
  bit qa[$];
  bit qb[$];

  serial_pattern_feeder #(.DATA_W(8), .BIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_valid(a_load_valid), .load_data(a_load_data), .msb_first(a_msb),
    .load_ready(a_load_ready), .bit_out(a_bit), .bit_valid(a_valid),
    .busy(a_busy), .done(a_done)
  );

  serial_pattern_feeder #(.DATA_W(8), .BIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .load_valid(b_load_valid), .load_data(b_load_data), .msb_first(b_msb),
    .load_ready(b_load_ready), .bit_out(b_bit), .bit_valid(b_valid),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic msb, input int reps, input bit to_b);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < reps; r++) begin
        if (to_b) qb.push_back(msb ? d[7-i] : d[i]);
        else      qa.push_back(msb ? d[7-i] : d[i]);
      end
    end
  endtask

  // One clock: capture pre-edge handshake state at negedge, sample outputs 1ns after posedge.
  task automatic tick();
    logic a_rdy, b_rdy, a_lv, b_lv, en;
    logic [3:0] a_prev, b_prev;
    @(negedge clk);
    a_rdy  = a_load_ready;
    b_rdy  = b_load_ready;
    a_lv   = a_load_valid;
    b_lv   = b_load_valid;
    en     = ena;
    a_prev = {a_bit, a_valid, a_busy, a_done};
    b_prev = {b_bit, b_valid, b_busy, b_done};
    @(posedge clk);
    #1;
    a_acc = en && a_rdy && a_lv;
    b_acc = en && b_rdy && b_lv;
    if (!en) begin
      check("a_freeze", {a_bit, a_valid, a_busy, a_done}, a_prev);
      check("b_freeze", {b_bit, b_valid, b_busy, b_done}, b_prev);
    end else begin
      if (a_valid) begin
        vcnt_a++;
        check("a_bit_expected", qa.size() != 0, 1);
        if (qa.size() != 0) check("a_bit", a_bit, qa.pop_front());
      end else begin
        check("a_bit_idle_zero", a_bit, 0);
      end
      if (a_done) done_a++;
      if (b_valid) begin
        vcnt_b++;
        check("b_bit_expected", qb.size() != 0, 1);
        if (qb.size() != 0) check("b_bit", b_bit, qb.pop_front());
      end else begin
        check("b_bit_idle_zero", b_bit, 0);
      end
      if (b_done) done_b++;
    end
  endtask

  task automatic wait_done(input bit sel_b, input int max);
    for (int i = 0; i < max; i++) begin
      if (sel_b ? (done_b != 0) : (done_a != 0)) break;
      tick();
    end
    check(sel_b ? "b_done_seen" : "a_done_seen", sel_b ? (done_b != 0) : (done_a != 0), 1);
  endtask

  initial begin
    clk = 0; rst_n = 1; ena = 1;
    a_load_valid = 0; a_load_data = 0; a_msb = 0;
    b_load_valid = 0; b_load_data = 0; b_msb = 0;
    vcnt_a = 0; vcnt_b = 0; done_a = 0; done_b = 0;
    a_acc = 0; b_acc = 0;
    #2 rst_n = 0;
    tick(); tick();
    check("reset_a", {a_load_ready, a_bit, a_valid, a_busy, a_done}, 5'b10000);
    check("reset_b", {b_load_ready, b_bit, b_valid, b_busy, b_done}, 5'b10000);
    rst_n = 1;
    tick();

    // 1: 0x0D MSB first
    a_load_data = 8'h0D; a_msb = 1; a_load_valid = 1;
    push_word(8'h0D, 1, 1, 0);
    vcnt_a = 0; done_a = 0;
    tick();
    check("t1_accept", a_acc, 1);
    check("t1_busy_ready", {a_busy, a_load_ready}, 2'b10);
    a_load_valid = 0; a_load_data = 8'hFF; a_msb = 0;
    wait_done(0, 40);
    check("t1_vcnt", vcnt_a, 8);
    check("t1_qempty", qa.size(), 0);
    check("t1_done_state", {a_load_ready, a_valid, a_busy, a_done}, 4'b1001);
    tick();
    check("t1_done_one_cycle", a_done, 0);

    // 2: 0x0D LSB first
    a_load_data = 8'h0D; a_msb = 0; a_load_valid = 1;
    push_word(8'h0D, 0, 1, 0);
    vcnt_a = 0; done_a = 0;
    tick();
    check("t2_accept", a_acc, 1);
    a_load_valid = 0;
    wait_done(0, 40);
    check("t2_vcnt", vcnt_a, 8);
    check("t2_qempty", qa.size(), 0);

    // 3: BIT_CYCLES=3, 0x80 MSB first
    b_load_data = 8'h80; b_msb = 1; b_load_valid = 1;
    push_word(8'h80, 1, 3, 1);
    vcnt_b = 0; done_b = 0;
    tick();
    check("t3_accept", b_acc, 1);
    b_load_valid = 0;
    wait_done(1, 100);
    check("t3_vcnt", vcnt_b, 24);
    check("t3_qempty", qb.size(), 0);

    // 4: reset after 4 bits of 0xFF
    a_load_data = 8'hFF; a_msb = 1; a_load_valid = 1;
    push_word(8'hFF, 1, 1, 0);
    done_a = 0;
    tick();
    check("t4_accept", a_acc, 1);
    a_load_valid = 0;
    tick(); tick(); tick();
    check("t4_four_bits_out", qa.size(), 4);
    rst_n = 0;
    #1;
    check("t4_async_reset", {a_load_ready, a_bit, a_valid, a_busy, a_done}, 5'b10000);
    qa.delete();
    tick(); tick();
    rst_n = 1;
    tick();
    check("t4_no_done", done_a, 0);
    a_load_data = 8'h0D; a_msb = 1; a_load_valid = 1;
    push_word(8'h0D, 1, 1, 0);
    vcnt_a = 0;
    tick();
    check("t4_accept_after_reset", a_acc, 1);
    a_load_valid = 0;
    wait_done(0, 40);
    check("t4_vcnt", vcnt_a, 8);

    // 5: ena low for 5 cycles mid-word
    tick();
    a_load_data = 8'hB4; a_msb = 1; a_load_valid = 1;
    push_word(8'hB4, 1, 1, 0);
    vcnt_a = 0; done_a = 0;
    tick();
    check("t5_accept", a_acc, 1);
    a_load_valid = 0;
    tick(); tick();
    ena = 0; a_load_valid = 1; a_load_data = 8'h00;
    repeat (5) tick();
    check("t5_ready_frozen", a_load_ready, 0);
    ena = 1; a_load_valid = 0;
    wait_done(0, 40);
    check("t5_vcnt", vcnt_a, 8);
    check("t5_qempty", qa.size(), 0);
    tick();
    ena = 0; a_load_valid = 1; a_load_data = 8'h5A; a_msb = 1;
    tick(); tick();
    check("t5_idle_not_accepted", {a_load_ready, a_valid}, 2'b00);
    ena = 1;
    push_word(8'h5A, 1, 1, 0);
    vcnt_a = 0; done_a = 0;
    tick();
    check("t5_accept_after_ena", a_acc, 1);
    a_load_valid = 0;
    wait_done(0, 40);
    check("t5b_vcnt", vcnt_a, 8);

    // 6: back-to-back 0xAA then 0x55
    tick();
    a_load_data = 8'hAA; a_msb = 1; a_load_valid = 1;
    push_word(8'hAA, 1, 1, 0);
    vcnt_a = 0; done_a = 0; gap = 0; acc2 = 0;
    tick();
    check("t6_accept1", a_acc, 1);
    a_load_data = 8'h55;
    push_word(8'h55, 1, 1, 0);
    for (int i = 0; i < 40 && qa.size() != 0; i++) begin
      tick();
      if (!a_valid) gap++;
      if (a_acc) begin
        acc2++;
        a_load_valid = 0;
      end
    end
    a_load_valid = 0;
    check("t6_drained", qa.size(), 0);
    check("t6_second_accept", acc2, 1);
`ifdef SER_CONT_EN
    check("t6_gap", gap, 0);
`else
    check("t6_gap", gap, 1);
`endif
    check("t6_first_done", done_a, 1);
    check("t6_vcnt", vcnt_a, 16);
    done_a = 0;
    wait_done(0, 40);
    tick();
    check("t6_final_idle", {a_load_ready, a_valid, a_busy, a_done}, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
